key_event_encoder: RTL and testbench

KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

---
 rtl/key_event_encoder.sv | 174 +++++++++++++++++
 tb/tb_key_event_encoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// Five-button front panel encoder: synchronize, debounce, queue press events.
// Define AUTO_REPEAT_EN to add auto-repeat on the four direction keys.
module key_event_encoder #(
  parameter int DEB_CYCLES   = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 7000000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       Up,
  input  logic       Down,
  input  logic       Left,
  input  logic       Right,
  input  logic       Select,
  output logic       ev_valid,
  output logic [2:0] ev_code,
  input  logic       ev_ready,
  output logic       overflow
);

  localparam int NK = 5;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Key index k carries event code k+1; Select (index 4) has top priority.
  logic [NK-1:0] raw;
  logic [NK-1:0] sync1;
  logic [NK-1:0] sync2;
  logic [NK-1:0] deb;
  logic [NK-1:0] deb_d;
  logic [NK-1:0] pend;
  logic [NK-1:0] rise;
  logic [NK-1:0] rep_tick;
  logic [NK-1:0] ev_new;
  logic [DW-1:0] deb_cnt [NK];

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [2:0]    mem [FIFO_DEPTH];
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          sel_valid;
  logic [2:0]    sel_idx;

  assign raw = {Select, Right, Left, Down, Up};

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      deb   <= '0;
      deb_d <= '0;
      for (int k = 0; k < NK; k++) deb_cnt[k] <= '0;
    end else begin
      deb_d <= deb;
      for (int k = 0; k < NK; k++) begin
        if (sync2[k] == deb[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DW'(DEB_CYCLES - 1)) begin
          deb[k]     <= sync2[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign rise = deb & ~deb_d;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt [NK-1];

  // Down-counter reloads with the initial delay on a press, then with the
  // repeat rate each time it reaches terminal count 1.
  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      for (int k = 0; k < NK - 1; k++) rep_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NK - 1; k++) begin
        if (!deb[k])
          rep_cnt[k] <= '0;
        else if (rise[k])
          rep_cnt[k] <= RW'(REPEAT_DELAY);
        else if (rep_cnt[k] == RW'(1))
          rep_cnt[k] <= RW'(REPEAT_RATE);
        else if (rep_cnt[k] != '0)
          rep_cnt[k] <= rep_cnt[k] - 1'b1;
      end
    end
  end

  always_comb begin
    rep_tick = '0;
    for (int k = 0; k < NK - 1; k++)
      rep_tick[k] = deb[k] && !rise[k] && (rep_cnt[k] == RW'(1));
  end
`else
  assign rep_tick = '0;
`endif

  assign ev_new = rise | rep_tick;

  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 3'd4;
    if (pend[4])      sel_idx = 3'd4;
    else if (pend[0]) sel_idx = 3'd0;
    else if (pend[1]) sel_idx = 3'd1;
    else if (pend[2]) sel_idx = 3'd2;
    else if (pend[3]) sel_idx = 3'd3;
    else begin
      sel_valid = 1'b0;
      sel_idx   = 3'd0;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ev_valid && ev_ready;
  assign push  = sel_valid && (!full || pop);

  // A press landing on a bit that is leaving this cycle re-arms it instead
  // of counting as a drop.
  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      for (int k = 0; k < NK; k++) begin
        if (ev_new[k]) begin
          if (pend[k] && !(push && sel_idx == 3'(k)))
            overflow <= 1'b1;
          else
            pend[k] <= 1'b1;
        end else if (push && sel_idx == 3'(k)) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sel_idx + 3'd1;
  end

  assign ev_valid = !empty;
  assign ev_code  = ev_valid ? mem[rd_ptr[AW-1:0]] : 3'd0;

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: an event-level model checked every cycle,
// plus directed scenarios with hand-computed event logs.
module tb_key_event_encoder;

  localparam int DEB   = 4;
  localparam int RD    = 20;
  localparam int RR    = 8;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] keys = '0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic       overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit started = 0;

  int log_cyc[$];
  int log_code[$];

  key_event_encoder #(
    .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .clear(clear),
    .Up(keys[0]), .Down(keys[1]), .Left(keys[2]), .Right(keys[3]), .Select(keys[4]),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  // Model: synced samples are the raw key two edges late; the debounced
  // level flips once the last DEB samples all disagree with it.
  bit m_s1[5], m_s2[5], m_deb[5], m_debd[5], m_pend[5];
  bit hist[5][DEB];
  int m_press[5];
  int m_q[$];
  bit m_ovf;

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_deb[k] = 0; m_debd[k] = 0; m_pend[k] = 0;
      m_press[k] = 0;
      for (int i = 0; i < DEB; i++) hist[k][i] = 0;
    end
    m_q.delete();
    m_ovf = 0;
  endtask

  task automatic model_step();
    bit pop, push, all_diff;
    bit rise[5], tick[5];
    int sel, el;
    pop = (m_q.size() > 0) && ev_ready;
    sel = -1;
    if (m_pend[4]) sel = 4;
    else for (int k = 0; k < 4; k++) if (m_pend[k] && sel < 0) sel = k;
    push = (sel >= 0) && (m_q.size() < DEPTH || pop);
    for (int k = 0; k < 5; k++) begin
      rise[k] = m_deb[k] && !m_debd[k];
      tick[k] = 0;
`ifdef AUTO_REPEAT_EN
      if (k < 4 && m_deb[k] && m_debd[k]) begin
        el = cyc - m_press[k];
        if (el == RD || (el > RD && (el - RD) % RR == 0)) tick[k] = 1;
      end
`endif
      if (rise[k]) m_press[k] = cyc;
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(sel + 1);
    for (int k = 0; k < 5; k++) begin
      if (rise[k] || tick[k]) begin
        if (m_pend[k] && !(push && sel == k)) m_ovf = 1;
        else m_pend[k] = 1;
      end else if (push && sel == k) begin
        m_pend[k] = 0;
      end
    end
    for (int k = 0; k < 5; k++) begin
      m_debd[k] = m_deb[k];
      for (int i = DEB - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = m_s2[k];
      all_diff = 1;
      for (int i = 0; i < DEB; i++) if (hist[k][i] == m_deb[k]) all_diff = 0;
      if (all_diff) m_deb[k] = !m_deb[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = keys[k];
    end
  endtask

  always @(posedge CLK) begin
    cyc++;
    if (clear) model_reset();
    else model_step();
  end

  always @(negedge CLK) begin
    bit ev, eo;
    int ec;
    if (started) begin
      ev = !clear && (m_q.size() > 0);
      ec = ev ? m_q[0] : 0;
      eo = !clear && m_ovf;
      total++;
      if (ev_valid !== ev || int'(ev_code) != ec || overflow !== eo) begin
        bad++;
        $display("FAIL outputs cyc=%0d valid=%0b exp %0b code=%0d exp %0d overflow=%0b exp %0b",
                 cyc, ev_valid, ev, ev_code, ec, overflow, eo);
      end
      if (ev_valid && ev_ready) begin
        log_cyc.push_back(cyc);
        log_code.push_back(int'(ev_code));
      end
    end
  end

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic tap(int k);
    keys[k] = 1'b1;
    step(6);
    keys[k] = 1'b0;
    step(8);
  endtask

  task automatic log_clear();
    log_cyc.delete();
    log_code.delete();
  endtask

  initial begin
    int c0;
    int offs[6];
    offs = '{0, 20, 28, 36, 44, 52};
    model_reset();
    #1 clear = 1'b1;
    #1 started = 1;
    step(3);
    check("reset_valid", int'(ev_valid), 0);
    check("reset_code", int'(ev_code), 0);
    check("reset_overflow", int'(overflow), 0);
    clear = 1'b0;
    step(2);

    // glitch shorter than DEB is ignored; a real press shows 2 cycles after debounce
    ev_ready = 1'b1;
    log_clear();
    keys[0] = 1'b1; step(3); keys[0] = 1'b0; step(12);
    check("short_press_events", log_code.size(), 0);
    c0 = cyc;
    keys[0] = 1'b1; step(10); keys[0] = 1'b0; step(12);
    check("up_event_count", log_code.size(), 1);
    check("up_code", log_code[0], 1);
    check("up_latency", log_cyc[0] - c0, 8);

    // simultaneous Up, Left, Select drain in priority order
    log_clear();
    keys = 5'b10101; step(10); keys = '0; step(12);
    check("multi_count", log_code.size(), 3);
    check("multi_code0", log_code[0], 5);
    check("multi_code1", log_code[1], 1);
    check("multi_code2", log_code[2], 3);
    check("multi_gap01", log_cyc[1] - log_cyc[0], 1);
    check("multi_gap12", log_cyc[2] - log_cyc[1], 1);
    check("multi_overflow", int'(overflow), 0);

    // fill the queue, park one pending Up, then drop a second Up
    ev_ready = 1'b0;
    log_clear();
    for (int k = 0; k < 4; k++) tap(k);
    check("full_valid", int'(ev_valid), 1);
    check("full_code", int'(ev_code), 1);
    tap(0);
    check("pending_overflow", int'(overflow), 0);
    tap(0);
    check("drop_overflow", int'(overflow), 1);
    check("drop_code", int'(ev_code), 1);
    ev_ready = 1'b1;
    step(10);
    check("drain_count", log_code.size(), 5);
    for (int i = 0; i < 4; i++) check("drain_code", log_code[i], i + 1);
    check("drain_code_last", log_code[4], 1);

    clear = 1'b1;
    step(1);
    check("clear_overflow", int'(overflow), 0);
    clear = 1'b0;
    step(2);

    // Right held 60 cycles
    log_clear();
    c0 = cyc;
    keys[3] = 1'b1; step(60); keys[3] = 1'b0; step(20);
    check("right_first_latency", log_cyc[0] - c0, 8);
`ifdef AUTO_REPEAT_EN
    check("right_count", log_code.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("right_offset", log_cyc[i] - log_cyc[0], offs[i]);
      check("right_code", log_code[i], 4);
    end
`else
    check("right_count", log_code.size(), 1);
    check("right_code", log_code[0], 4);
`endif

    // Select never repeats
    log_clear();
    keys[4] = 1'b1; step(100); keys[4] = 1'b0; step(15);
    check("select_count", log_code.size(), 1);
    check("select_code", log_code[0], 5);

    // clear with two queued events and Down mid-debounce
    ev_ready = 1'b0;
    log_clear();
    tap(0);
    tap(2);
    check("queued_valid", int'(ev_valid), 1);
    keys[1] = 1'b1;
    step(3);
    clear = 1'b1;
    step(1);
    check("clr_valid", int'(ev_valid), 0);
    check("clr_code", int'(ev_code), 0);
    check("clr_overflow", int'(overflow), 0);
    clear = 1'b0;
    step(15);
    ev_ready = 1'b1;
    step(5);
    keys[1] = 1'b0;
    step(12);
    check("redebounce_count", log_code.size(), 1);
    check("redebounce_code", log_code[0], 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
